// File: rtl/frame_read_buffer.sv
// rtl/frame_read_buffer.sv - SDRAM frame fetch into a show-ahead pixel FIFO (option: FRAME_READ_UNDERFLOW_CNT_EN)
module frame_read_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int FRAME_WORDS = 130560,
  parameter int BURST_LEN   = 128,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                          video_clk,
  input  logic                          rst_n,
  input  logic                          read_req,
  output logic                          read_req_ack,
  input  logic                          read_en,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          rd_burst_req,
  output logic [ADDR_WIDTH-1:0]         rd_burst_addr,
  output logic [9:0]                    rd_burst_len,
  input  logic                          rd_burst_ack,
  input  logic                          rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]         rd_burst_data,
  input  logic                          rd_burst_finish,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          overflow
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  , output logic [15:0]                 underflow_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_CHECK, S_REQ, S_DATA, S_DONE} state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW:0]             wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  logic [DATA_WIDTH-1:0]   head_n;
  logic [17:0]             issued, remain;
  logic [9:0]              len_n;
  logic                    full, empty, push, pop, space_ok;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == (PW+1)'(FIFO_DEPTH));
  assign empty      = (fifo_level == '0);
  // Words only enter while a burst is in flight; stray data outside DATA is ignored.
  assign push       = (state == S_DATA) && rd_burst_data_valid && !full;
  assign pop        = read_en && !empty;
  assign remain     = 18'(FRAME_WORDS) - issued;
  assign len_n      = (remain < 18'(BURST_LEN)) ? remain[9:0] : 10'(BURST_LEN);
  assign space_ok   = (fifo_level <= (PW+1)'(FIFO_DEPTH - BURST_LEN));

  // Next FIFO pointers and the head word the registered show-ahead output will present.
  always_comb begin
    wr_ptr_n = wr_ptr + (PW+1)'(push);
    rd_ptr_n = rd_ptr + (PW+1)'(pop);
    level_n  = wr_ptr_n - rd_ptr_n;
    head_n   = '0;
    if (level_n != '0) begin
      if (rd_ptr_n == wr_ptr) head_n = rd_burst_data;
      else                    head_n = mem[rd_ptr_n[PW-1:0]];
    end
  end

  // Next-state decode; CHECK/REQ may be preempted, DATA only yields at burst end.
  always_comb begin
    state_n      = state;
    read_req_ack = 1'b0;
    rd_burst_req = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (read_req) state_n = S_ACK;
      S_ACK: begin
        read_req_ack = 1'b1;
        state_n      = S_CHECK;
      end
      S_CHECK: begin
        if (read_req)                         state_n = S_ACK;
        else if (issued == 18'(FRAME_WORDS))  state_n = S_DONE;
        else if (space_ok)                    state_n = S_REQ;
      end
      S_REQ: begin
        rd_burst_req = 1'b1;
        if (read_req)          state_n = S_ACK;
        else if (rd_burst_ack) state_n = S_DATA;
      end
      S_DATA: begin
        if (rd_burst_finish) state_n = read_req ? S_ACK : S_CHECK;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Burst address, length and issued-word bookkeeping.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      issued        <= '0;
      rd_burst_addr <= BASE_ADDR;
      rd_burst_len  <= '0;
    end else if (state == S_ACK) begin
      issued        <= '0;
      rd_burst_addr <= BASE_ADDR;
    end else if (state == S_CHECK && state_n == S_REQ) begin
      rd_burst_len  <= len_n;
    end else if (state == S_DATA && rd_burst_finish) begin
      issued        <= issued + 18'(rd_burst_len);
      rd_burst_addr <= rd_burst_addr + ADDR_WIDTH'(rd_burst_len);
    end
  end

  // FIFO storage; no reset needed since pointers define validity.
  always_ff @(posedge video_clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= rd_burst_data;
  end

  // FIFO pointers, registered head word and status flags; ACK flushes the FIFO.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      read_data <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= read_en && empty;
      if (state == S_ACK) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        read_data <= '0;
        overflow  <= 1'b0;
      end else begin
        wr_ptr    <= wr_ptr_n;
        rd_ptr    <= rd_ptr_n;
        read_data <= head_n;
        if (state == S_DATA && rd_burst_data_valid && full) overflow <= 1'b1;
      end
    end
  end

`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  // Saturating count of empty pops; survives frame accepts.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                                        underflow_cnt <= '0;
    else if (read_en && empty && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_read_buffer.sv
// tb/tb_frame_read_buffer.sv - directed bench for frame_read_buffer
module tb_frame_read_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_req = 1'b0;
  logic        read_req_ack;
  logic        read_en = 1'b0;
  logic [15:0] read_data;
  logic        rd_burst_req;
  logic [23:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic        rd_burst_ack = 1'b0;
  logic        rd_burst_data_valid = 1'b0;
  logic [15:0] rd_burst_data = '0;
  logic        rd_burst_finish = 1'b0;
  logic [9:0]  fifo_level;
  logic        underflow;
  logic        overflow;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  frame_read_buffer #(.FRAME_WORDS(300), .BURST_LEN(128)) dut (
    .video_clk(clk), .rst_n(rst_n), .read_req(read_req), .read_req_ack(read_req_ack),
    .read_en(read_en), .read_data(read_data), .rd_burst_req(rd_burst_req),
    .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len), .rd_burst_ack(rd_burst_ack),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish), .fifo_level(fifo_level), .underflow(underflow),
    .overflow(overflow)
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int max_cyc);
    bit ok = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (rd_burst_req) begin ok = 1; break; end
    end
    check("req_wait", 32'(ok), 32'd1);
  endtask

  task automatic serve_burst(input logic [23:0] ea, input int el, input int n,
                             input logic [15:0] base, input int pre_at, input bit chk_first);
    int acks = 0;
    wait_req(20);
    check("burst_addr", 32'(rd_burst_addr), 32'(ea));
    check("burst_len", 32'(rd_burst_len), 32'(el));
    rd_burst_ack = 1'b1;
    @(negedge clk);
    rd_burst_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == pre_at) read_req = 1'b1;
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = base + 16'(i);
      rd_burst_finish     = (i == n - 1);
      @(negedge clk);
      if (read_req_ack && i != n - 1) acks++;
      if (i == 0 && chk_first) begin
        check("first_level", 32'(fifo_level), 32'd1);
        check("first_data", 32'(read_data), 32'(base));
      end
    end
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
    if (pre_at >= 0) check("no_ack_in_data", 32'(acks), 32'd0);
  endtask

  task automatic quiet_req(input string tag, input int cyc);
    int seen = 0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      if (rd_burst_req) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic frame_accept();
    read_req = 1'b1;
    @(negedge clk);
    check("ack_pulse", 32'(read_req_ack), 32'd1);
    read_req = 1'b0;
    @(negedge clk);
    check("ack_low", 32'(read_req_ack), 32'd0);
    check("flush_level", 32'(fifo_level), 32'd0);
    check("ovf_cleared", 32'(overflow), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(read_req_ack), 32'd0);
    check("rst_data", 32'(read_data), 32'd0);
    check("rst_req", 32'(rd_burst_req), 32'd0);
    check("rst_addr", 32'(rd_burst_addr), 32'd0);
    check("rst_len", 32'(rd_burst_len), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame of 300 words: bursts 0/128/256 with lengths 128/128/44.
    frame_accept();
    check("req_not_yet", 32'(rd_burst_req), 32'd0);
    @(negedge clk);
    check("req_rise", 32'(rd_burst_req), 32'd1);
    serve_burst(24'd0,   128, 128, 16'd0,   -1, 1);
    check("lvl_b1", 32'(fifo_level), 32'd128);
    serve_burst(24'd128, 128, 128, 16'd128, -1, 0);
    serve_burst(24'd256, 44,  44,  16'd256, -1, 0);
    quiet_req("done_quiet", 20);
    check("lvl_frame", 32'(fifo_level), 32'd300);

    // Drain: show-ahead data, then one empty pop.
    for (int i = 0; i < 300; i++) begin
      read_en = 1'b1;
      check("drain", 32'(read_data), 32'(i));
      @(negedge clk);
    end
    check("drain_level", 32'(fifo_level), 32'd0);
    check("empty_data", 32'(read_data), 32'd0);
    check("unf_before", 32'(underflow), 32'd0);
    @(negedge clk);
    read_en = 1'b0;
    check("unf_pulse", 32'(underflow), 32'd1);
    check("unf_data", 32'(read_data), 32'd0);
    @(negedge clk);
    check("unf_end", 32'(underflow), 32'd0);

    // Backpressure: 400 words stored, request held off until level <= 384.
    frame_accept();
    serve_burst(24'd0, 128, 400, 16'h1000, -1, 1);
    check("lvl_400", 32'(fifo_level), 32'd400);
    quiet_req("bp_quiet_400", 20);
    for (int i = 0; i < 15; i++) begin
      read_en = 1'b1;
      check("bp_pop", 32'(read_data), 32'h1000 + 32'(i));
      @(negedge clk);
    end
    read_en = 1'b0;
    check("lvl_385", 32'(fifo_level), 32'd385);
    quiet_req("bp_quiet_385", 10);
    read_en = 1'b1;
    check("bp_pop16", 32'(read_data), 32'h100F);
    @(negedge clk);
    read_en = 1'b0;

    // Frame request during DATA: ack lands the cycle after finish.
    serve_burst(24'd128, 128, 10, 16'h2000, 3, 0);
    check("late_ack", 32'(read_req_ack), 32'd1);
    read_req = 1'b0;
    @(negedge clk);
    check("late_flush", 32'(fifo_level), 32'd0);
    check("late_data", 32'(read_data), 32'd0);

    // Overflow: 640 words into an empty FIFO.
    serve_burst(24'd0, 128, 640, 16'h3000, -1, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd512);
    check("ovf_head", 32'(read_data), 32'h3000);
    quiet_req("ovf_quiet", 10);
    frame_accept();

    // Preempt while REQ is pending.
    wait_req(5);
    check("pre_addr", 32'(rd_burst_addr), 32'd0);
    read_req = 1'b1;
    @(negedge clk);
    check("pre_ack", 32'(read_req_ack), 32'd1);
    check("pre_req_drop", 32'(rd_burst_req), 32'd0);
    read_req = 1'b0;
    wait_req(5);
    check("pre_addr2", 32'(rd_burst_addr), 32'd0);
    check("pre_len2", 32'(rd_burst_len), 32'd128);

    // Asynchronous reset mid-burst, then stray data ignored.
    rd_burst_ack = 1'b1;
    @(negedge clk);
    rd_burst_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data = 16'h4000 + 16'(i);
      @(negedge clk);
    end
    check("mid_level", 32'(fifo_level), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_req", 32'(rd_burst_req), 32'd0);
    check("arst_data", 32'(read_data), 32'd0);
    check("arst_len", 32'(rd_burst_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_burst_finish = (i == 4);
      @(negedge clk);
    end
    rd_burst_data_valid = 1'b0;
    rd_burst_finish = 1'b0;
    @(negedge clk);
    check("stray_level", 32'(fifo_level), 32'd0);
    check("stray_req", 32'(rd_burst_req), 32'd0);
    check("stray_ack", 32'(read_req_ack), 32'd0);

`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    check("ucnt_rst", 32'(underflow_cnt), 32'd0);
    read_en = 1'b1;
    repeat (3) @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    check("ucnt_3", 32'(underflow_cnt), 32'd3);
    read_en = 1'b1;
    repeat (70000) @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    check("ucnt_sat", 32'(underflow_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_read_buffer.md
# frame_read_buffer

Frame-read front end for the LCD video path. It accepts the per-frame `read_req` from the video timing stage and fetches one frame of pixels from SDRAM through a burst-read port. It buffers the pixels in an internal show-ahead FIFO and serves them on `read_en`/`read_data` with zero read latency. It sits between the SDRAM read arbiter and the LCD timing/data stage, entirely in the pixel clock domain.

## Interface
- `DATA_WIDTH`, 16, pixel word width
- `ADDR_WIDTH`, 24, SDRAM word address width
- `BASE_ADDR`, 0, word address of pixel (0,0)
- `FRAME_WORDS`, 130560, words per frame (480×272)
- `BURST_LEN`, 128, maximum words per burst; must be ≤ 511
- `FIFO_DEPTH`, 512, power of 2 and ≥ 2×`BURST_LEN`

- `video_clk` in 1: pixel clock, sole clock
- `rst_n` in 1: asynchronous, active-low reset
- `read_req` in 1: frame start request, level, held until ack
- `read_req_ack` out 1: one-cycle accept pulse
- `read_en` in 1: pop FIFO head this cycle
- `read_data` out `DATA_WIDTH`: FIFO head, valid in the same cycle as `read_en`
- `rd_burst_req` out 1: burst request, held until `rd_burst_ack`
- `rd_burst_addr` out `ADDR_WIDTH`: burst start word address
- `rd_burst_len` out 10: burst length in words
- `rd_burst_ack` in 1: arbiter accepted the burst
- `rd_burst_data_valid` in 1: `rd_burst_data` valid this cycle
- `rd_burst_data` in `DATA_WIDTH`: returned word
- `rd_burst_finish` in 1: last word of burst done, one-cycle pulse
- `fifo_level` out clog2(`FIFO_DEPTH`)+1: words stored
- `underflow` out 1: one-cycle pulse, `read_en` while FIFO empty
- `overflow` out 1: sticky, data arrived while FIFO full; cleared by reset or frame accept

## Operation
- FSM states: IDLE, ACK, CHECK, REQ, DATA, DONE.
- IDLE/DONE → ACK when `read_req`=1.
- CHECK/REQ → ACK when `read_req`=1. Preemption is allowed because no data is outstanding in these states.
- DATA never preempts. A pending `read_req` is taken on the cycle after `rd_burst_finish`.
- ACK: `read_req_ack`=1 for one cycle. FIFO is flushed (pointers zeroed, contents discarded). Word counter `issued` cleared, address set to `BASE_ADDR`, `overflow` cleared. Next state CHECK.
- CHECK, if `issued` = `FRAME_WORDS` → DONE.
- CHECK, else if free space (`FIFO_DEPTH` − `fifo_level`) ≥ `BURST_LEN` → REQ. The length is latched as min(`BURST_LEN`, `FRAME_WORDS` − `issued`).
- CHECK, otherwise stay in CHECK.
- REQ: `rd_burst_req`=1, with address and length stable. On `rd_burst_ack` → DATA.
- DATA: each `rd_burst_data_valid` writes one word. On `rd_burst_finish`: `issued` += length, address += length → CHECK.
- FIFO write while full: the word is dropped and `overflow` is set. Pointers are not corrupted.
- Simultaneous FIFO push and pop: allowed, level unchanged. Pop on empty: `read_data`=0, pointers unchanged, `underflow` pulses.
- Address and counter arithmetic is unsigned, at `ADDR_WIDTH` and 18 bits respectively. Address wraps modulo 2^`ADDR_WIDTH`.

## Timing
- Reset values: `read_req_ack`=0, `read_data`=0, `rd_burst_req`=0, `rd_burst_addr`=`BASE_ADDR`, `rd_burst_len`=0, `fifo_level`=0, `underflow`=0, `overflow`=0. FSM resets to IDLE.
- `read_req` is sampled at edge N and `read_req_ack` is high during cycle N+1.
- First `rd_burst_req` rises 2 cycles after the ack cycle.
- A written word is visible on `read_data` and counted in `fifo_level` the cycle after its `rd_burst_data_valid`.
- `read_data` is the FIFO head, registered output, show-ahead.
- `read_en` at edge N pops; `read_data` shows the next word from cycle N+1.
- Reset asserted mid-burst: everything returns to reset values immediately. Data arriving after reset release is ignored until the next accepted frame.

## Configuration
- `FRAME_READ_UNDERFLOW_CNT_EN` defined: adds output `underflow_cnt` [15:0]. It counts `underflow` pulses, saturates at 16'hFFFF, and clears on reset only. It is not cleared on a frame accept.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Defaults overridden with `FRAME_WORDS`=300, `BURST_LEN`=128. Pulse `read_req` → one ack; bursts at address 0/128/256 with lengths 128/128/44, then DONE.
- Fill FIFO to 400 words with no `read_en` → no further `rd_burst_req` until `fifo_level` ≤ 384.
- Pop continuously starting at `fifo_level`=1 → `read_data` presents word 0 in the same cycle; the next word appears on the following cycle; `underflow` pulses once the FIFO is empty, with `read_data`=0.
- `read_req` raised during DATA → ack is delayed until the cycle after `rd_burst_finish`. FIFO flushes to 0 and the next burst address is `BASE_ADDR`.
- Burst returning 129 words into a FIFO holding 511 words → `overflow`=1, `fifo_level`=512; the next frame accept clears `overflow`.
- With `FRAME_READ_UNDERFLOW_CNT_EN`: 3 empty pops → `underflow_cnt`=3. Forcing 70000 empty pops → counter holds at 65535.
